// File: rtl/hi_lo_mult_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hi_lo_mult_div_pkg                                                   |
// | Shared constants and the control-state encoding of the Hi/Lo unit.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hi_lo_mult_div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hi_lo_mult_div_restoring_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | restoring_div_step                                                   |
// | One combinational restoring-division step: shift in a dividend bit,  |
// | trial-subtract the divisor, keep the difference when it fits.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {rem_in, dividend_bit};
  // rem_in < divisor, so a successful difference always fits in WIDTH bits
  assign w_diff  = w_shift[WIDTH-1:0] - divisor;
  assign q_bit   = (w_shift >= {1'b0, divisor});
  assign rem_out = q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/hi_lo_mult_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hi_lo_mult_div                                                       |
// | Iterative signed multiply/divide owning the Hi and Lo registers.     |
// | Optional MULT_DIV_UNSIGNED_EN adds unsigned_op for MULTU/DIVU.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hi_lo_mult_div #(
  parameter int WIDTH = hi_lo_mult_div_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import hi_lo_mult_div_pkg::*;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;      // MULT: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_b;      // multiplicand or divisor magnitude
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_add;
  logic [WIDTH-1:0]   w_rem;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULT_DIV_UNSIGNED_EN
  assign w_signed = ~unsigned_op;
`else
  assign w_signed = 1'b1;
`endif

  assign w_sa = w_signed & op_a[WIDTH-1];
  assign w_sb = w_signed & op_b[WIDTH-1];
  assign w_ma = w_sa ? -op_a : op_a;
  assign w_mb = w_sb ? -op_b : op_b;

  assign w_add = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (r_p[2*WIDTH-1:WIDTH]),
    .dividend_bit (r_p[WIDTH-1]),
    .divisor      (r_b),
    .rem_out      (w_rem),
    .q_bit        (w_qbit)
  );

  assign w_prod_fix = r_neg_q ? -r_p : r_p;
  assign w_quo_fix  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_mult) begin
            r_p      <= {{WIDTH{1'b0}}, w_mb};
            r_b      <= w_ma;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            r_state  <= MULT;
          end else if (start_div) begin
            div_zero <= (op_b == '0);
            if (op_b == '0) begin
              r_state <= DONE;
            end else begin
              r_p      <= {{WIDTH{1'b0}}, w_ma};
              r_b      <= w_mb;
              r_neg_q  <= w_sa ^ w_sb;
              r_neg_r  <= w_sa;
              r_is_div <= 1'b1;
              r_cnt    <= '0;
              busy     <= 1'b1;
              r_state  <= DIV;
            end
          end
        end
        MULT, DIV: begin
          if (r_state == MULT) r_p <= {w_add, r_p[WIDTH-1:1]};
          else                 r_p <= {w_rem, r_p[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_is_div) begin
            hi <= w_rem_fix;
            lo <= w_quo_fix;
          end else begin
            {hi, lo} <= w_prod_fix;
          end
          busy    <= 1'b0;
          r_state <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_mult_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hi_lo_mult_div                                                    |
// | Scoreboard bench: directed vectors with hand-computed Hi/Lo results. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hi_lo_mult_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        uop = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  hi_lo_mult_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MULT_DIV_UNSIGNED_EN
    .unsigned_op(uop),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_cyc;
    int          lat;
    int          busy_cycles;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   op_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          m_e = q.pop_front();
          check($sformatf("op%0d_hi", m_e.id), {32'd0, hi}, {32'd0, m_e.hi});
          check($sformatf("op%0d_lo", m_e.id), {32'd0, lo}, {32'd0, m_e.lo});
          check($sformatf("op%0d_div_zero", m_e.id), {63'd0, div_zero}, {63'd0, m_e.dz});
          check($sformatf("op%0d_latency", m_e.id), 64'(cyc - m_e.start_cyc), 64'(m_e.lat));
          check($sformatf("op%0d_busy_cycles", m_e.id), 64'(busy_cnt), 64'(m_e.busy_cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic u, input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat, input int bc);
    exp_t e;
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    uop        = u;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz;
      e.start_cyc = cyc; e.lat = lat; e.busy_cycles = bc; e.id = op_id;
      q.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    uop        = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results pending after %0d cycles, expected 0", q.size(), bound);
      q.delete();
    end
  endtask

  task automatic op(input logic m, input logic [31:0] a, input logic [31:0] b, input logic u,
                    input logic [31:0] eh, input logic [31:0] el);
    issue(m, ~m, a, b, u, 1'b1, eh, el, 1'b0, 35, 33);
    wait_idle(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
    op(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, 32'd0, 32'd30);
    op(1'b0, 32'h5678_1234, 32'h0001_0000, 1'b0, 32'h1234, 32'h5678);

    // divide by zero keeps Hi/Lo from the previous operation
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h5678, 1'b1, 2, 0);
    wait_idle(20);
    op(1'b1, 32'd2, 32'd3, 1'b0, 32'd0, 32'd6);

    op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'd0);

    // start_div mid-MULT must be dropped
    issue(1'b1, 1'b0, 32'h0001_2345, 32'h100, 1'b0, 1'b1, 32'd0, 32'h0123_4500, 1'b0, 35, 33);
    repeat (5) @(negedge clk);
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0, 0);
    wait_idle(100);
    repeat (3) @(negedge clk);

    // reset ten cycles into a MULT aborts it without a done pulse
    issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    op(1'b1, 32'd4, 32'd5, 1'b0, 32'd0, 32'd20);

`ifdef MULT_DIV_UNSIGNED_EN
    op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE);
    op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'hF, 32'h0FFF_FFFF);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
